dot_score_tracker: RTL and testbench

Consumer of the per-dot `eaten` flags from the array of dot instances. Each dot is credited at most once per level. The block keeps a saturating score, the number of dots remaining and the level number, and detects level clear. After clear it drives a rearm pulse into every dot instance's Reset so the board refills. It sits between the dot array and the score/HUD display logic.

---
 rtl/dot_score_pkg.sv | 19 +
 rtl/dot_score_tracker_if.sv | 29 ++
 rtl/dot_popcount.sv | 18 +
 rtl/dot_score_tracker.sv | 110 +++++++++++
 tb/tb_dot_score_tracker.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/dot_score_pkg.sv
// Shared types and helpers for the dot score tracker: FSM states, level limits, counter width.
package dot_score_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        REARM      = 2'd1,
        PLAY       = 2'd2,
        CLEAR_WAIT = 2'd3
    } tracker_state_t;

    localparam int LEVEL_W = 8;
    localparam logic [LEVEL_W-1:0] LEVEL_MAX = 8'd255;

    // Bits needed to hold a count from 0 to n inclusive.
    function automatic int dcw(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/dot_score_tracker_if.sv
// Control, dot-flag and HUD signals between the dot array/game logic and the score tracker.
interface dot_score_tracker_if
    import dot_score_pkg::*;
#(
    parameter int NUM_DOTS = 64,
    parameter int SCORE_W  = 16
) ();
    localparam int DCW = dcw(NUM_DOTS);

    logic                start;
    logic                abort;
    logic [NUM_DOTS-1:0] eaten;
    logic [SCORE_W-1:0]  score;
    logic [LEVEL_W-1:0]  level;
    logic [DCW-1:0]      dots_left;
    logic                dots_rearm;
    logic                level_clear;
    logic                playing;

    modport master (
        output start, abort, eaten,
        input  score, level, dots_left, dots_rearm, level_clear, playing
    );

    modport slave (
        input  start, abort, eaten,
        output score, level, dots_left, dots_rearm, level_clear, playing
    );
endinterface

// File: rtl/dot_popcount.sv
// Combinational population count of an N-bit vector; zero latency, no flow control.
module dot_popcount
    import dot_score_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [N-1:0]       bits,
    output logic [dcw(N)-1:0]  count
);
    localparam int CW = dcw(N);

    always_comb begin
        count = '0;
        for (int i = 0; i < N; i++) begin
            count = count + CW'(bits[i]);
        end
    end
endmodule

// File: rtl/dot_score_tracker.sv
// Credits each dot once per level into a saturating score, tracks dots left/level, rearms the board after clear.
// Newly risen eaten bits show in score/dots_left one edge later; no backpressure, abort wins over everything.
module dot_score_tracker
    import dot_score_pkg::*;
#(
    parameter int NUM_DOTS     = 64,
    parameter int DOT_POINTS   = 10,
    parameter int SCORE_W      = 16,
    parameter int CLEAR_CYCLES = 16
) (
    input  logic              Clk,
    input  logic              Reset,
    dot_score_tracker_if.slave bus
);
    localparam int DCW   = dcw(NUM_DOTS);
    localparam int SUM_W = SCORE_W + DCW + 1;
    localparam int TW    = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;
    localparam logic [SUM_W-1:0] SCORE_MAX_EXT = (SUM_W'(1) << SCORE_W) - SUM_W'(1);
    localparam logic [TW-1:0]    TIMER_LAST    = TW'(CLEAR_CYCLES - 1);

    tracker_state_t      state;
    logic [NUM_DOTS-1:0] counted;
    logic [SCORE_W-1:0]  score_q;
    logic [LEVEL_W-1:0]  level_q;
    logic [DCW-1:0]      dots_left_q;
    logic [TW-1:0]       timer;
    logic                rearm_q;
    logic                clear_q;

    logic [NUM_DOTS-1:0] new_bits;
    logic [DCW-1:0]      n_new;
    logic [SUM_W-1:0]    gain;
    logic [SUM_W-1:0]    sum;
    logic [SCORE_W-1:0]  score_next;

    assign new_bits = bus.eaten & ~counted;

    dot_popcount #(.N(NUM_DOTS)) u_popcount (
        .bits  (new_bits),
        .count (n_new)
    );

    // Product and sum are carried wide enough that saturation is decided before any wrap.
    always_comb begin
        gain       = SUM_W'(n_new) * SUM_W'(DOT_POINTS);
        sum        = SUM_W'(score_q) + gain;
        score_next = (sum > SCORE_MAX_EXT) ? '1 : sum[SCORE_W-1:0];
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state       <= IDLE;
            counted     <= '0;
            score_q     <= '0;
            level_q     <= '0;
            dots_left_q <= DCW'(NUM_DOTS);
            timer       <= '0;
            rearm_q     <= 1'b0;
            clear_q     <= 1'b0;
        end else begin
            rearm_q <= 1'b0;
            clear_q <= 1'b0;
            if (bus.abort) begin
                state <= IDLE;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (bus.start) begin
                            score_q <= '0;
                            level_q <= '0;
                            state   <= REARM;
                            rearm_q <= 1'b1;
                        end
                    end
                    REARM: begin
                        counted     <= '0;
                        dots_left_q <= DCW'(NUM_DOTS);
                        level_q     <= (level_q == LEVEL_MAX) ? level_q : level_q + 8'd1;
                        state       <= PLAY;
                    end
                    PLAY: begin
                        counted     <= counted | new_bits;
                        dots_left_q <= dots_left_q - n_new;
                        score_q     <= score_next;
                        if (dots_left_q == n_new) begin
                            state   <= CLEAR_WAIT;
                            clear_q <= 1'b1;
                            timer   <= '0;
                        end
                    end
                    CLEAR_WAIT: begin
                        timer <= timer + TW'(1);
                        if (timer == TIMER_LAST) begin
                            state   <= REARM;
                            rearm_q <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.score       = score_q;
    assign bus.level       = level_q;
    assign bus.dots_left   = dots_left_q;
    assign bus.dots_rearm  = rearm_q;
    assign bus.level_clear = clear_q;
    assign bus.playing     = (state == PLAY);
endmodule

// File: tb/tb_dot_score_tracker.sv
// Directed table, saturation and async-reset sequences, then randomized play against a reference model.
module tb_dot_score_tracker;
    logic Clk = 1'b0;
    logic Reset = 1'b1;
    int checks = 0;
    int failures = 0;

    always #5 Clk = ~Clk;

    dot_score_tracker_if #(.NUM_DOTS(8), .SCORE_W(16)) ifa ();
    dot_score_tracker_if #(.NUM_DOTS(8), .SCORE_W(8))  ifb ();

    dot_score_tracker #(.NUM_DOTS(8), .DOT_POINTS(10), .SCORE_W(16), .CLEAR_CYCLES(4)) u_a (
        .Clk(Clk), .Reset(Reset), .bus(ifa)
    );
    dot_score_tracker #(.NUM_DOTS(8), .DOT_POINTS(100), .SCORE_W(8), .CLEAR_CYCLES(4)) u_b (
        .Clk(Clk), .Reset(Reset), .bus(ifb)
    );

    typedef struct {
        logic       start;
        logic       abort;
        logic [7:0] eaten;
        int         score;
        int         level;
        int         left;
        logic       rearm;
        logic       clr;
        logic       play;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(logic s, logic a, logic [7:0] e, int sc, int lv, int lf,
                                logic r, logic c, logic p);
        vec_t v;
        v.start = s; v.abort = a; v.eaten = e;
        v.score = sc; v.level = lv; v.left = lf;
        v.rearm = r; v.clr = c; v.play = p;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk_a(input string tag, input int sc, input int lv, input int lf,
                         input int r, input int c, input int p);
        chk({tag, ".score"},       int'(ifa.score),       sc);
        chk({tag, ".level"},       int'(ifa.level),       lv);
        chk({tag, ".dots_left"},   int'(ifa.dots_left),   lf);
        chk({tag, ".dots_rearm"},  int'(ifa.dots_rearm),  r);
        chk({tag, ".level_clear"}, int'(ifa.level_clear), c);
        chk({tag, ".playing"},     int'(ifa.playing),     p);
    endtask

    // Reference model: game phase, per-dot credit flags, cycles spent waiting after a clear.
    localparam int PH_IDLE = 0, PH_REARM = 1, PH_PLAY = 2, PH_WAIT = 3;
    int m_phase, m_score, m_level, m_left, m_waited;
    bit m_credited [8];
    int m_rearm, m_clr;

    task automatic model_reset();
        m_phase = PH_IDLE; m_score = 0; m_level = 0; m_left = 8; m_waited = 0;
        m_rearm = 0; m_clr = 0;
        foreach (m_credited[i]) m_credited[i] = 1'b0;
    endtask

    task automatic model_step(input bit s, input bit a, input logic [7:0] e);
        int gained;
        m_rearm = 0;
        m_clr   = 0;
        if (a) begin
            m_phase = PH_IDLE;
        end else if (m_phase == PH_IDLE) begin
            if (s) begin
                m_score = 0; m_level = 0; m_phase = PH_REARM; m_rearm = 1;
            end
        end else if (m_phase == PH_REARM) begin
            foreach (m_credited[i]) m_credited[i] = 1'b0;
            m_left  = 8;
            m_level = (m_level < 255) ? m_level + 1 : 255;
            m_phase = PH_PLAY;
        end else if (m_phase == PH_PLAY) begin
            gained = 0;
            for (int i = 0; i < 8; i++) begin
                if (e[i] && !m_credited[i]) begin
                    m_credited[i] = 1'b1;
                    gained++;
                end
            end
            m_left  -= gained;
            m_score += gained * 10;
            if (m_score > 65535) m_score = 65535;
            if (m_left == 0) begin
                m_phase = PH_WAIT; m_clr = 1; m_waited = 0;
            end
        end else begin
            m_waited++;
            if (m_waited == 4) begin
                m_phase = PH_REARM; m_rearm = 1;
            end
        end
    endtask

    initial begin
        logic [7:0] ev;
        bit s, a;

        ifa.start = 0; ifa.abort = 0; ifa.eaten = '0;
        ifb.start = 0; ifb.abort = 0; ifb.eaten = '0;
        #23;
        chk_a("reset", 0, 0, 8, 0, 0, 0);
        Reset = 1'b0;

        // start, single dot, multi-dot rise, drop/re-raise, start ignored, clear, rearm, abort on last dot
        vt.push_back(mk(1, 0, 8'h00,   0, 0, 8, 1, 0, 0));
        vt.push_back(mk(0, 0, 8'h00,   0, 1, 8, 0, 0, 1));
        for (int i = 0; i < 5; i++)
            vt.push_back(mk(0, 0, 8'h01, 10, 1, 7, 0, 0, 1));
        vt.push_back(mk(0, 0, 8'h07,  30, 1, 5, 0, 0, 1));
        vt.push_back(mk(0, 0, 8'h05,  30, 1, 5, 0, 0, 1));
        vt.push_back(mk(0, 0, 8'h07,  30, 1, 5, 0, 0, 1));
        vt.push_back(mk(1, 0, 8'h07,  30, 1, 5, 0, 0, 1));
        vt.push_back(mk(0, 0, 8'hFF,  80, 1, 0, 0, 1, 0));
        vt.push_back(mk(0, 0, 8'hFF,  80, 1, 0, 0, 0, 0));
        vt.push_back(mk(1, 0, 8'hFF,  80, 1, 0, 0, 0, 0));
        vt.push_back(mk(0, 0, 8'hFF,  80, 1, 0, 0, 0, 0));
        vt.push_back(mk(0, 0, 8'h00,  80, 1, 0, 1, 0, 0));
        vt.push_back(mk(0, 0, 8'h00,  80, 2, 8, 0, 0, 1));
        vt.push_back(mk(0, 0, 8'h7F, 150, 2, 1, 0, 0, 1));
        vt.push_back(mk(0, 1, 8'hFF, 150, 2, 1, 0, 0, 0));
        vt.push_back(mk(0, 0, 8'hFF, 150, 2, 1, 0, 0, 0));
        vt.push_back(mk(1, 0, 8'h00,   0, 0, 1, 1, 0, 0));
        vt.push_back(mk(0, 0, 8'h00,   0, 1, 8, 0, 0, 1));

        @(negedge Clk);
        for (int i = 0; i < vt.size(); i++) begin
            ifa.start = vt[i].start;
            ifa.abort = vt[i].abort;
            ifa.eaten = vt[i].eaten;
            tick();
            chk_a($sformatf("vec%0d", i), vt[i].score, vt[i].level, vt[i].left,
                  vt[i].rearm, vt[i].clr, vt[i].play);
        end
        ifa.start = 0; ifa.abort = 0; ifa.eaten = '0;

        // Saturation: 3 dots at 100 points into an 8-bit score.
        ifb.start = 1; tick();
        ifb.start = 0; tick();
        chk("sat.playing", int'(ifb.playing), 1);
        ifb.eaten = 8'h07; tick();
        chk("sat.score", int'(ifb.score), 255);
        chk("sat.dots_left", int'(ifb.dots_left), 5);
        ifb.eaten = 8'h0F; tick();
        chk("sat.score_hold", int'(ifb.score), 255);
        chk("sat.dots_left2", int'(ifb.dots_left), 4);

        // Asynchronous reset landing mid-CLEAR_WAIT, between clock edges.
        ifa.eaten = 8'hFF; tick();
        chk("cw.level_clear", int'(ifa.level_clear), 1);
        chk("cw.score", int'(ifa.score), 80);
        tick();
        #2 Reset = 1'b1;
        #1;
        chk_a("arst", 0, 0, 8, 0, 0, 0);
        chk("arst.b_score", int'(ifb.score), 0);
        ifa.eaten = '0;
        @(negedge Clk);
        Reset = 1'b0;

        model_reset();
        for (int cyc = 0; cyc < 1500; cyc++) begin
            s = ($urandom_range(7) == 0);
            a = ($urandom_range(59) == 0);
            ev = ifa.eaten;
            if ($urandom_range(3) == 0) ev[$urandom_range(7)] = 1'b1;
            if ($urandom_range(15) == 0) ev[$urandom_range(7)] = 1'b0;
            if (m_phase == PH_REARM && $urandom_range(1) == 0) ev = '0;
            ifa.start = s; ifa.abort = a; ifa.eaten = ev;
            model_step(s, a, ev);
            tick();
            chk_a($sformatf("rnd%0d", cyc), m_score, m_level, m_left,
                  m_rearm, m_clr, (m_phase == PH_PLAY) ? 1 : 0);
            @(negedge Clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
